// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the RAM port arbiter: FSM state encoding and
// requester grant identifiers.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_RESP   = 2'd2
    } arb_state_e;

    localparam logic GNT_IF = 1'b0;
    localparam logic GNT_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_chk.sv
// Simulation checker for the requester handshake: the granted requester
// must keep req high for the whole RAM access.
module mem_port_arbiter_chk
    import mem_port_arbiter_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic in_access,
    input  logic cur_gnt,
    input  logic if_req,
    input  logic ls_req
);

    a_req_held_during_access: assert property (
        @(posedge clk) disable iff (!rst_n)
        in_access |-> ((cur_gnt == GNT_IF) ? if_req : ls_req)
    );

endmodule

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Two-requester round-robin picker. Purely combinational so it can sit in
// front of any shared resource whose owner keeps the last_gnt history.
// req[0] is the GNT_IF requester, req[1] the GNT_LS requester.
module rr_arb2
    import mem_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic       gnt_valid,
    output logic       gnt_id
);

    // Single requester wins outright; on a tie the one not granted last wins.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = GNT_IF;
        case (req)
            2'b01: begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_IF;
            end
            2'b10: begin
                gnt_valid = 1'b1;
                gnt_id    = GNT_LS;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                gnt_id    = ~last_gnt;
            end
            default: begin
                gnt_valid = 1'b0;
                gnt_id    = GNT_IF;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch (IF) and load/store (LS).
// Each access: grant in IDLE, hold ram_cs for RAM_LAT cycles in ACCESS,
// pulse the winner's ack in RESP. All outputs come straight from flops.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int RAM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy
);

    localparam int CNT_W = ($clog2(RAM_LAT + 1) > 1) ? $clog2(RAM_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(RAM_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    generate
        if (RAM_LAT < 1) begin : g_bad_lat
            $error("mem_port_arbiter: RAM_LAT must be at least 1");
        end
    endgenerate

    arb_state_e        state_r;
    logic [CNT_W-1:0]  lat_cnt_r;
    logic              cur_gnt_r;
    logic              last_gnt_r;
    logic              if_ack_r;
    logic              ls_ack_r;
    logic [DATA_W-1:0] if_rdata_r;
    logic [DATA_W-1:0] ls_rdata_r;
    logic              ram_cs_r;
    logic              ram_we_r;
    logic              ram_oe_r;
    logic [ADDR_W-1:0] ram_addr_r;
    logic [DATA_W-1:0] ram_wdata_r;
    logic              busy_r;

    logic              gnt_valid_s;
    logic              gnt_id_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic              sel_we_s;
    logic [DATA_W-1:0] sel_wdata_s;

    rr_arb2 u_rr_arb2 (
        .req       ({ls_req, if_req}),
        .last_gnt  (last_gnt_r),
        .gnt_valid (gnt_valid_s),
        .gnt_id    (gnt_id_s)
    );

    // Route the winning requester's command; fetches are always reads and
    // leave the write-data register untouched.
    always_comb begin
        sel_addr_s  = if_addr;
        sel_we_s    = 1'b0;
        sel_wdata_s = ram_wdata_r;
        if (gnt_id_s == GNT_LS) begin
            sel_addr_s  = ls_addr;
            sel_we_s    = ls_we;
            sel_wdata_s = ls_wdata;
        end else begin
            sel_addr_s  = if_addr;
            sel_we_s    = 1'b0;
            sel_wdata_s = ram_wdata_r;
        end
    end

    // Arbiter FSM with latency counter and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ARB_IDLE;
            lat_cnt_r   <= {CNT_W{1'b0}};
            cur_gnt_r   <= GNT_IF;
            last_gnt_r  <= GNT_LS;
            if_ack_r    <= 1'b0;
            ls_ack_r    <= 1'b0;
            if_rdata_r  <= {DATA_W{1'b0}};
            ls_rdata_r  <= {DATA_W{1'b0}};
            ram_cs_r    <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_oe_r    <= 1'b0;
            ram_addr_r  <= {ADDR_W{1'b0}};
            ram_wdata_r <= {DATA_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    if_ack_r <= 1'b0;
                    ls_ack_r <= 1'b0;
                    if (gnt_valid_s) begin
                        state_r     <= ARB_ACCESS;
                        cur_gnt_r   <= gnt_id_s;
                        last_gnt_r  <= gnt_id_s;
                        lat_cnt_r   <= LAT_INIT;
                        ram_cs_r    <= 1'b1;
                        ram_we_r    <= sel_we_s;
                        ram_oe_r    <= ~sel_we_s;
                        ram_addr_r  <= sel_addr_s;
                        ram_wdata_r <= sel_wdata_s;
                        busy_r      <= 1'b1;
                    end else begin
                        ram_cs_r <= 1'b0;
                        ram_we_r <= 1'b0;
                        ram_oe_r <= 1'b0;
                        busy_r   <= 1'b0;
                    end
                end
                ARB_ACCESS: begin
                    if (lat_cnt_r == {CNT_W{1'b0}}) begin
                        state_r  <= ARB_RESP;
                        ram_cs_r <= 1'b0;
                        ram_we_r <= 1'b0;
                        ram_oe_r <= 1'b0;
                        if (cur_gnt_r == GNT_IF) begin
                            if_rdata_r <= ram_rdata;
                            if_ack_r   <= 1'b1;
                        end else begin
                            ls_ack_r <= 1'b1;
                            if (!ram_we_r) begin
                                ls_rdata_r <= ram_rdata;
                            end else begin
                                ls_rdata_r <= ls_rdata_r;
                            end
                        end
                    end else begin
                        lat_cnt_r <= lat_cnt_r - CNT_ONE;
                    end
                end
                ARB_RESP: begin
                    state_r  <= ARB_IDLE;
                    if_ack_r <= 1'b0;
                    ls_ack_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
                default: begin
                    state_r  <= ARB_IDLE;
                    if_ack_r <= 1'b0;
                    ls_ack_r <= 1'b0;
                    ram_cs_r <= 1'b0;
                    ram_we_r <= 1'b0;
                    ram_oe_r <= 1'b0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    assign if_ack    = if_ack_r;
    assign ls_ack    = ls_ack_r;
    assign if_rdata  = if_rdata_r;
    assign ls_rdata  = ls_rdata_r;
    assign ram_cs    = ram_cs_r;
    assign ram_we    = ram_we_r;
    assign ram_oe    = ram_oe_r;
    assign ram_addr  = ram_addr_r;
    assign ram_wdata = ram_wdata_r;
    assign busy      = busy_r;

    mem_port_arbiter_chk u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_access (state_r == ARB_ACCESS),
        .cur_gnt   (cur_gnt_r),
        .if_req    (if_req),
        .ls_req    (ls_req)
    );

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one RAM_LAT=1 instance and one
// RAM_LAT=3 instance, each scenario a task with its own inline checks.
module tb_mem_port_arbiter;

    logic        clk;
    int          n_checks;
    int          n_fail;

    // RAM_LAT = 1 instance
    logic        rst_n, if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata, ram_rdata;
    logic        if_ack, ls_ack, ram_cs, ram_we, ram_oe, busy;
    logic [31:0] if_rdata, ls_rdata, ram_addr, ram_wdata;

    // RAM_LAT = 3 instance
    logic        rst3_n, if_req3, ls_req3, ls_we3;
    logic [31:0] if_addr3, ls_addr3, ls_wdata3, ram_rdata3;
    logic        if_ack3, ls_ack3, ram_cs3, ram_we3, ram_oe3, busy3;
    logic [31:0] if_rdata3, ls_rdata3, ram_addr3, ram_wdata3;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RAM_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst3_n),
        .if_req(if_req3), .if_addr(if_addr3), .if_ack(if_ack3), .if_rdata(if_rdata3),
        .ls_req(ls_req3), .ls_we(ls_we3), .ls_addr(ls_addr3), .ls_wdata(ls_wdata3),
        .ls_ack(ls_ack3), .ls_rdata(ls_rdata3),
        .ram_cs(ram_cs3), .ram_we(ram_we3), .ram_oe(ram_oe3), .ram_addr(ram_addr3),
        .ram_wdata(ram_wdata3), .ram_rdata(ram_rdata3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [133:0] out1;
        logic [133:0] out3;
        rst_n = 1'b0; rst3_n = 1'b0;
        if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
        if_addr = 32'h0; ls_addr = 32'h0; ls_wdata = 32'h0; ram_rdata = 32'h0;
        if_req3 = 1'b0; ls_req3 = 1'b0; ls_we3 = 1'b0;
        if_addr3 = 32'h0; ls_addr3 = 32'h0; ls_wdata3 = 32'h0; ram_rdata3 = 32'h0;
        tick();
        tick();
        out1 = {if_ack, ls_ack, ram_cs, ram_we, ram_oe, busy,
                if_rdata, ls_rdata, ram_addr, ram_wdata};
        out3 = {if_ack3, ls_ack3, ram_cs3, ram_we3, ram_oe3, busy3,
                if_rdata3, ls_rdata3, ram_addr3, ram_wdata3};
        n_checks++;
        if (out1 !== 134'h0) begin
            n_fail++; $display("FAIL reset_outputs_lat1: got %h want 0", out1);
        end
        n_checks++;
        if (out3 !== 134'h0) begin
            n_fail++; $display("FAIL reset_outputs_lat3: got %h want 0", out3);
        end
        rst_n = 1'b1; rst3_n = 1'b1;
        tick();
        n_checks++;
        if ({ram_cs, busy} !== 2'b00) begin
            n_fail++; $display("FAIL reset_idle: cs/busy got %b want 00", {ram_cs, busy});
        end
    endtask

    task automatic test_if_only();
        ram_rdata = 32'h00500093;
        if_addr = 32'h10; if_req = 1'b1;
        tick();
        n_checks++;
        if ({ram_cs, ram_oe, ram_we, busy, if_ack} !== 5'b11010) begin
            n_fail++; $display("FAIL if_only_access: cs/oe/we/busy/ack got %b want 11010",
                               {ram_cs, ram_oe, ram_we, busy, if_ack});
        end
        n_checks++;
        if (ram_addr !== 32'h10) begin
            n_fail++; $display("FAIL if_only_addr: got %h want 00000010", ram_addr);
        end
        tick();
        n_checks++;
        if ({if_ack, ls_ack, ram_cs} !== 3'b100) begin
            n_fail++; $display("FAIL if_only_ack: if_ack/ls_ack/cs got %b want 100",
                               {if_ack, ls_ack, ram_cs});
        end
        n_checks++;
        if (if_rdata !== 32'h00500093) begin
            n_fail++; $display("FAIL if_only_rdata: got %h want 00500093", if_rdata);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if ({if_ack, busy} !== 2'b00) begin
            n_fail++; $display("FAIL if_only_done: ack/busy got %b want 00", {if_ack, busy});
        end
    endtask

    task automatic test_ls_store();
        ram_rdata = 32'hCAFEF00D;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF;
        tick();
        n_checks++;
        if ({ram_cs, ram_we, ram_oe} !== 3'b110) begin
            n_fail++; $display("FAIL store_strobes: cs/we/oe got %b want 110",
                               {ram_cs, ram_we, ram_oe});
        end
        n_checks++;
        if ({ram_addr, ram_wdata} !== {32'h40, 32'hDEADBEEF}) begin
            n_fail++; $display("FAIL store_addr_data: got %h %h want 00000040 deadbeef",
                               ram_addr, ram_wdata);
        end
        tick();
        n_checks++;
        if ({ls_ack, if_ack, ram_cs, ram_we} !== 4'b1000) begin
            n_fail++; $display("FAIL store_ack: ls_ack/if_ack/cs/we got %b want 1000",
                               {ls_ack, if_ack, ram_cs, ram_we});
        end
        n_checks++;
        if (ls_rdata !== 32'h0) begin
            n_fail++; $display("FAIL store_rdata_kept: got %h want 00000000", ls_rdata);
        end
        ls_req = 1'b0; ls_we = 1'b0;
        tick();
        n_checks++;
        if ({ls_ack, ram_addr} !== {1'b0, 32'h40}) begin
            n_fail++; $display("FAIL store_idle_hold: ack %b addr %h want 0 00000040",
                               ls_ack, ram_addr);
        end
    endtask

    task automatic test_back_to_back();
        logic exp_if, exp_ls, exp_cs;
        logic [31:0] exp_addr;
        rst_n = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h100;
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200;
        ram_rdata = 32'h11112222;
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_if   = (k == 2) || (k == 8);
            exp_ls   = (k == 5) || (k == 11);
            exp_cs   = (k % 3) == 1;
            exp_addr = ((k == 4) || (k == 10)) ? 32'h200 : 32'h100;
            n_checks++;
            if ({if_ack, ls_ack, ram_cs} !== {exp_if, exp_ls, exp_cs}) begin
                n_fail++; $display("FAIL b2b_cycle%0d: if_ack/ls_ack/cs got %b want %b",
                                   k, {if_ack, ls_ack, ram_cs}, {exp_if, exp_ls, exp_cs});
            end
            if (exp_cs) begin
                n_checks++;
                if (ram_addr !== exp_addr) begin
                    n_fail++; $display("FAIL b2b_addr%0d: got %h want %h", k, ram_addr, exp_addr);
                end
            end
            if (k == 11) begin
                if_req = 1'b0; ls_req = 1'b0;
            end
        end
    endtask

    task automatic test_addr_change();
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        if_addr = 32'h20;
        n_checks++;
        if ({ram_cs, ram_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL addr_change_access: cs %b addr %h want 1 00000010",
                               ram_cs, ram_addr);
        end
        tick();
        n_checks++;
        if ({if_ack, ram_addr} !== {1'b1, 32'h10}) begin
            n_fail++; $display("FAIL addr_change_resp: ack %b addr %h want 1 00000010",
                               if_ack, ram_addr);
        end
        if_req = 1'b0;
        tick();
        n_checks++;
        if (ram_addr !== 32'h10) begin
            n_fail++; $display("FAIL addr_change_idle: got %h want 00000010", ram_addr);
        end
    endtask

    task automatic test_lat3_load();
        logic exp_cs, exp_ack;
        ram_rdata3 = 32'hBAD0BAD0;
        ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h8;
        for (int k = 1; k <= 5; k++) begin
            tick();
            exp_cs  = (k <= 3);
            exp_ack = (k == 4);
            n_checks++;
            if ({ram_cs3, ram_oe3, ls_ack3} !== {exp_cs, exp_cs, exp_ack}) begin
                n_fail++; $display("FAIL lat3_cycle%0d: cs/oe/ls_ack got %b want %b",
                                   k, {ram_cs3, ram_oe3, ls_ack3}, {exp_cs, exp_cs, exp_ack});
            end
            if (exp_cs) begin
                n_checks++;
                if (ram_addr3 !== 32'h8) begin
                    n_fail++; $display("FAIL lat3_addr%0d: got %h want 00000008", k, ram_addr3);
                end
            end
            if (k >= 4) begin
                n_checks++;
                if (ls_rdata3 !== 32'h12345678) begin
                    n_fail++; $display("FAIL lat3_rdata%0d: got %h want 12345678", k, ls_rdata3);
                end
            end
            if (k == 3) ram_rdata3 = 32'h12345678;
            if (k == 4) begin
                ram_rdata3 = 32'hBAD0BAD0;
                ls_req3 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid_access();
        logic [133:0] out3;
        logic         exp_ack;
        if_req3 = 1'b1; if_addr3 = 32'h30;
        tick();
        ls_req3 = 1'b1; ls_we3 = 1'b0; ls_addr3 = 32'h34;
        tick();
        rst3_n = 1'b0;
        #1;
        out3 = {if_ack3, ls_ack3, ram_cs3, ram_we3, ram_oe3, busy3,
                if_rdata3, ls_rdata3, ram_addr3, ram_wdata3};
        n_checks++;
        if (out3 !== 134'h0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %h want 0", out3);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            n_checks++;
            if ({if_ack3, ls_ack3, ram_cs3} !== 3'b000) begin
                n_fail++; $display("FAIL mid_reset_no_ack%0d: got %b want 000",
                                   k, {if_ack3, ls_ack3, ram_cs3});
            end
        end
        rst3_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            exp_ack = (k == 4);
            if (k <= 3) begin
                n_checks++;
                if ({ram_cs3, ram_addr3} !== {1'b1, 32'h30}) begin
                    n_fail++; $display("FAIL post_reset_if_first%0d: cs %b addr %h want 1 00000030",
                                       k, ram_cs3, ram_addr3);
                end
            end
            n_checks++;
            if ({if_ack3, ls_ack3} !== {exp_ack, 1'b0}) begin
                n_fail++; $display("FAIL post_reset_ack%0d: if/ls got %b want %b",
                                   k, {if_ack3, ls_ack3}, {exp_ack, 1'b0});
            end
            if (k == 4) if_req3 = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_if_only();
        test_ls_store();
        test_back_to_back();
        test_addr_change();
        test_lat3_load();
        test_reset_mid_access();
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port instruction/data RAM between two requesters: the instruction-fetch path (IF, driven by the control FSM's fetch state) and a load/store path (LS, for future LW/SW).
- Owns the `ram_cs`/`ram_we`/`ram_oe` strobes that the control FSM drives directly today. It runs a req/ack handshake per requester with two-way round-robin arbitration and a fixed RAM access latency.

Parameters:
- ADDR_W, 32, RAM address width.
- DATA_W, 32, RAM data width.
- RAM_LAT, 1, cycles `ram_cs` is held per access; read data is valid on the last of them. Must be ≥1.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle pulse: fetch done, if_rdata valid
- if_rdata  out  DATA_W  fetched word
- ls_req  in  1  load/store request, held until ls_ack
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  ADDR_W  load/store address
- ls_wdata  in  DATA_W  store data
- ls_ack  out  1  one-cycle pulse: load/store done
- ls_rdata  out  DATA_W  loaded word, valid with ls_ack
- ram_cs  out  1  RAM chip select
- ram_we  out  1  RAM write enable
- ram_oe  out  1  RAM output enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data
- busy  out  1  1 whenever state ≠ IDLE

Behaviour:
- Reset: while rst_n=0, every output is 0, state=IDLE, lat_cnt=0 and last_gnt=LS, so IF wins the first tie. Reset takes effect immediately, including mid-access; a transaction in flight is dropped with no ack.
- States: IDLE, ACCESS, RESP. All outputs are registered.
- IDLE:
  - If exactly one req is high, grant it.
  - If both are high, grant the one ≠ last_gnt.
  - On a grant: latch addr, we (IF is always a read) and wdata into the ram_* regs. Set cur_gnt, set last_gnt = cur_gnt, set lat_cnt = RAM_LAT-1, and go to ACCESS.
  - If neither req is high, stay in IDLE with ram_cs=ram_we=ram_oe=0.
- ACCESS:
  - ram_cs=1, ram_we=latched we, ram_oe=!latched we. ram_addr and ram_wdata are held stable.
  - When lat_cnt=0: capture ram_rdata into the granted requester's rdata reg (loads and fetches only; a store leaves ls_rdata unchanged) and go to RESP.
  - Otherwise decrement lat_cnt.
- RESP:
  - ram_cs/we/oe=0; the granted requester's ack=1 for exactly this cycle.
  - Next state is IDLE.
- Latency: req sampled high at edge E0 → ram_cs high for cycles E0+1 .. E0+RAM_LAT → ack high in cycle E0+RAM_LAT+1. Back-to-back throughput is one access per RAM_LAT+2 cycles.
- Requester rules:
  - The requester drops req on the edge that samples its ack, so IDLE does not re-grant the finished request.
  - addr/we/wdata may change any time after the grant edge, since they are latched.
- Withdrawing req during ACCESS is a protocol violation. The access still completes and the ack still pulses; a simulation-only assertion flags it.
- Starvation: under continuous dual requests the grants strictly alternate IF, LS, IF, LS…
- rdata regs hold their value between acks. ram_addr/ram_wdata hold their last value in IDLE and RESP.
- lat_cnt width is $clog2(RAM_LAT+1), minimum 1.
- RAM_LAT=0 is illegal: elaboration-time check with $error.

Decomposition:
- Shared cpu package holds:
  - state encoding: ARB_IDLE, ARB_ACCESS, ARB_RESP, 2 bits;
  - grant IDs: GNT_IF=1'b0, GNT_LS=1'b1.
- Sub-module rr_arb2: a combinational two-requester round-robin picker. Inputs req[1:0] and last_gnt; outputs gnt_valid and gnt_id. It is reusable for future shared resources such as a multi-cycle divider.
- The FSM, latency counter and datapath registers stay in mem_port_arbiter.

Test Plan:
- IF only, RAM_LAT=1: if_req=1 at E0, if_addr=0x10, RAM returns 0x00500093 → ram_cs=1, ram_oe=1 in E0+1; if_ack=1 and if_rdata=0x00500093 in E0+2; ls_ack stays 0.
- LS store: ls_req=1, ls_we=1, addr 0x40, wdata 0xDEADBEEF → ram_cs=1, ram_we=1, ram_oe=0, ram_addr=0x40, ram_wdata=0xDEADBEEF for one cycle; then ls_ack pulses; ls_rdata unchanged.
- Simultaneous: both reqs held continuously for 4 transactions after reset → grant order IF, LS, IF, LS; each ack is 1 cycle wide, spaced 3 cycles apart.
- RAM_LAT=3 build, load from 0x8 returning 0x12345678 → ram_cs high exactly 3 cycles with ram_addr stable; ls_ack in cycle E0+4 with ls_rdata=0x12345678.
- Reset mid-ACCESS: assert rst_n=0 in the second ACCESS cycle → all outputs 0 immediately, no ack. After release with both reqs high, IF is granted first.
- Address change after grant: change if_addr from 0x10 to 0x20 in the cycle after the grant edge → ram_addr stays 0x10 through the whole access.
